step_clk_gen: RTL and testbench

//  Multi-channel programmable step-clock generator; one independent divider per motor axis.

---
 rtl/step_clk_pkg.sv | 24 ++
 rtl/step_clk_chan.sv | 187 ++++++++++++++++++
 rtl/step_clk_gen.sv | 49 ++++
 tb/tb_step_clk_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : step_clk_pkg
//  Brief    : Shared defaults and FSM state encoding for the step-clock
//             generator (step_clk_chan / step_clk_gen).
//  Revision : 1.0 - initial release
// ============================================================================
package step_clk_pkg;

    // Default divisor/counter width: half-period in clk cycles
    localparam int CNT_W_DEF  = 21;
    // Default pulse-count width (only meaningful with STEP_CLK_PCNT_EN)
    localparam int PCNT_W_DEF = 16;
    // Default number of channels
    localparam int NUM_CH_DEF = 2;

    // Per-channel run state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } step_state_e;

endpackage
`default_nettype wire

// File: rtl/step_clk_chan.sv
`default_nettype none
// ============================================================================
//  Module   : step_clk_chan
//  Brief    : One step-clock channel. 50% duty square wave with a half-period
//             of div_act cycles, a 1-cycle tick per rising edge, divisor
//             updates only at half-period boundaries and stop handling that
//             never truncates a high phase.
//             Optional feature macro: STEP_CLK_PCNT_EN (pulse counter + done).
//  Revision : 1.0 - initial release
// ============================================================================
module step_clk_chan
    import step_clk_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PCNT_W = PCNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [CNT_W-1:0]  div_in_i,
    input  logic [PCNT_W-1:0] pcnt_target_i,
    output logic              clk_out_o,
    output logic              tick_o,
    output logic              busy_o,
    output logic              done_o
);

    step_state_e       state_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  div_act_q;
    logic [CNT_W-1:0]  shadow_q;
    logic              pending_q;
    logic              clk_out_q;
    logic              tick_q;

    logic [CNT_W-1:0]  div_m1;
    logic              boundary;
    logic [CNT_W-1:0]  next_div;
    logic              pcnt_hit;
    logic              stop_req;
    logic              start_ok;

`ifdef STEP_CLK_PCNT_EN
    logic [PCNT_W-1:0] pcnt_q;
    logic              done_q;
    logic              hold_q;   // set on target reached, cleared once en drops
`endif

    // Boundary detection and divisor selection for the next half-period
    always_comb begin
        div_m1   = div_act_q - CNT_W'(1);
        // >= so that a divisor that shrank cannot make the counter run past it
        boundary = (count_q >= div_m1);
        // A load coinciding with a boundary takes effect at that boundary
        if (load_i) begin
            next_div = div_in_i;
        end else if (pending_q) begin
            next_div = shadow_q;
        end else begin
            next_div = div_act_q;
        end
    end

`ifdef STEP_CLK_PCNT_EN
    // Pulse target reached (target 0 means run without limit)
    always_comb begin
        pcnt_hit = (pcnt_target_i != '0) && (pcnt_q == pcnt_target_i);
        stop_req = !en_i || pcnt_hit;
        start_ok = en_i && (div_act_q != '0) && !hold_q;
    end
`else
    // Without the pulse counter the en level alone controls running
    logic w_unused_pcnt;
    always_comb begin
        w_unused_pcnt = ^pcnt_target_i;
        pcnt_hit      = 1'b0;
        stop_req      = !en_i;
        start_ok      = en_i && (div_act_q != '0);
    end
`endif

    // Channel FSM: counter, divisor shadowing, output wave and tick
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            div_act_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
`ifdef STEP_CLK_PCNT_EN
            pcnt_q    <= '0;
            done_q    <= 1'b0;
            hold_q    <= 1'b0;
`endif
        end else begin
            tick_q <= 1'b0;
            if (load_i) begin
                shadow_q <= div_in_i;
            end
            case (state_q)
                ST_IDLE: begin
                    count_q   <= '0;
                    clk_out_q <= 1'b0;
                    // While idle a divisor takes effect directly
                    if (load_i) begin
                        div_act_q <= div_in_i;
                        pending_q <= 1'b0;
                    end else if (pending_q) begin
                        div_act_q <= shadow_q;
                        pending_q <= 1'b0;
                    end
`ifdef STEP_CLK_PCNT_EN
                    if (!en_i) begin
                        hold_q <= 1'b0;
                    end
`endif
                    if (start_ok) begin
                        state_q <= ST_RUN;
`ifdef STEP_CLK_PCNT_EN
                        pcnt_q  <= '0;
                        done_q  <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    if (load_i) begin
                        pending_q <= 1'b1;
                    end
                    if (stop_req && !clk_out_q) begin
                        // Low phase may be cut short: no pulse is emitted
                        state_q <= ST_IDLE;
                        count_q <= '0;
`ifdef STEP_CLK_PCNT_EN
                        if (pcnt_hit) begin
                            done_q <= 1'b1;
                            hold_q <= 1'b1;
                        end
`endif
                    end else if (boundary) begin
                        count_q   <= '0;
                        div_act_q <= next_div;
                        pending_q <= 1'b0;
                        if (stop_req || (next_div == '0)) begin
                            // High phase has just completed (or we are low):
                            // end low and go idle
                            clk_out_q <= 1'b0;
                            state_q   <= ST_IDLE;
`ifdef STEP_CLK_PCNT_EN
                            if (pcnt_hit) begin
                                done_q <= 1'b1;
                                hold_q <= 1'b1;
                            end
`endif
                        end else begin
                            clk_out_q <= !clk_out_q;
                            if (!clk_out_q) begin
                                tick_q <= 1'b1;
`ifdef STEP_CLK_PCNT_EN
                                pcnt_q <= pcnt_q + PCNT_W'(1);
`endif
                            end
                        end
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign busy_o    = (state_q == ST_RUN) || clk_out_q;
`ifdef STEP_CLK_PCNT_EN
    assign done_o    = done_q;
`else
    assign done_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/step_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : step_clk_gen
//  Brief    : Multi-channel programmable step-clock generator, one
//             independent step_clk_chan per motor axis; slices the flattened
//             divisor and pulse-target buses per channel.
//             Optional feature macro: STEP_CLK_PCNT_EN (pulse counter + done).
//  Revision : 1.0 - initial release
// ============================================================================
module step_clk_gen
    import step_clk_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int PCNT_W = PCNT_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_CH-1:0]        en_i,
    input  logic [NUM_CH-1:0]        load_i,
    input  logic [NUM_CH*CNT_W-1:0]  div_in_i,
    input  logic [NUM_CH*PCNT_W-1:0] pcnt_target_i,
    output logic [NUM_CH-1:0]        clk_out_o,
    output logic [NUM_CH-1:0]        tick_o,
    output logic [NUM_CH-1:0]        busy_o,
    output logic [NUM_CH-1:0]        done_o
);

    // One fully independent channel per axis
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        step_clk_chan #(
            .CNT_W  (CNT_W),
            .PCNT_W (PCNT_W)
        ) u_chan (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .en_i          (en_i[gi]),
            .load_i        (load_i[gi]),
            .div_in_i      (div_in_i[gi*CNT_W +: CNT_W]),
            .pcnt_target_i (pcnt_target_i[gi*PCNT_W +: PCNT_W]),
            .clk_out_o     (clk_out_o[gi]),
            .tick_o        (tick_o[gi]),
            .busy_o        (busy_o[gi]),
            .done_o        (done_o[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_step_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_step_clk_gen
//  Brief    : Self-checking bench for step_clk_gen: table of single-channel
//             divisor cases plus directed multi-cycle corner sequences.
//             Optional feature macro: STEP_CLK_PCNT_EN (pulse-target test).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_step_clk_gen;

    localparam int CNT_W  = 21;
    localparam int NUM_CH = 2;
    localparam int PCNT_W = 16;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_CH-1:0]        en = '0;
    logic [NUM_CH-1:0]        load = '0;
    logic [NUM_CH*CNT_W-1:0]  div_in = '0;
    logic [NUM_CH*PCNT_W-1:0] pcnt_target = '0;
    logic [NUM_CH-1:0]        clk_out;
    logic [NUM_CH-1:0]        tick;
    logic [NUM_CH-1:0]        busy;
    logic [NUM_CH-1:0]        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ch;
        int div;
        int exp_lat;   // edges from en=1 to first rising sample
        int exp_half;  // high and low phase length in cycles
    } vec_t;

    vec_t vecs [5];

    step_clk_gen #(
        .CNT_W  (CNT_W),
        .NUM_CH (NUM_CH),
        .PCNT_W (PCNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .en_i          (en),
        .load_i        (load),
        .div_in_i      (div_in),
        .pcnt_target_i (pcnt_target),
        .clk_out_o     (clk_out),
        .tick_o        (tick),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_div(input int ch, input int d);
        load[ch] = 1'b1;
        div_in[ch*CNT_W +: CNT_W] = CNT_W'(d);
        cyc();
        load[ch] = 1'b0;
    endtask

    // Wait (bounded) for clk_out[ch] high; n = edges waited, -1 on timeout
    task automatic wait_rise(input int ch, output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            cyc();
            if (clk_out[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    // Length of the current phase at 'level', counting from 'start' samples
    // already seen; stray ticks inside the phase accumulate in bad_ticks
    task automatic measure_half(input int ch, input logic level, input int start,
                                output int len, inout int bad_ticks);
        len = -1;
        for (int i = start; i <= 200; i++) begin
            cyc();
            if (clk_out[ch] != level) begin
                len = i;
                break;
            end
            if (tick[ch]) bad_ticks++;
        end
    endtask

    task automatic stop_ch(input int ch);
        en[ch] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (!busy[ch]) break;
        end
        check("stop_busy", int'(busy[ch]), 0);
    endtask

    initial begin
        int n, h, l, bad;
        int cnt [NUM_CH];
        int last [NUM_CH];
        int badint [NUM_CH];
        int mism [NUM_CH];
        logic [NUM_CH-1:0] prev;
        int per [NUM_CH];

        vecs[0] = '{ch: 0, div: 4, exp_lat: 5, exp_half: 4};
        vecs[1] = '{ch: 0, div: 1, exp_lat: 2, exp_half: 1};
        vecs[2] = '{ch: 1, div: 5, exp_lat: 6, exp_half: 5};
        vecs[3] = '{ch: 1, div: 2, exp_lat: 3, exp_half: 2};
        vecs[4] = '{ch: 0, div: 7, exp_lat: 8, exp_half: 7};

        // ---- reset with en high, then divisor 0 keeps channels idle
        rst_n = 1'b0;
        en    = '1;
        repeat (5) cyc();
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick",    int'(tick),    0);
        check("rst_busy",    int'(busy),    0);
        check("rst_done",    int'(done),    0);
        rst_n = 1'b1;
        repeat (5) cyc();
        check("div0_busy",    int'(busy),    0);
        check("div0_clk_out", int'(clk_out), 0);
        en = '0;
        cyc();

        // ---- table: latency, phase lengths and tick alignment per divisor
        foreach (vecs[i]) begin
            bad = 0;
            load_div(vecs[i].ch, vecs[i].div);
            en[vecs[i].ch] = 1'b1;
            wait_rise(vecs[i].ch, n);
            check($sformatf("v%0d_latency", i), n, vecs[i].exp_lat);
            check($sformatf("v%0d_tick_rise1", i), int'(tick[vecs[i].ch]), 1);
            measure_half(vecs[i].ch, 1'b1, 1, h, bad);
            check($sformatf("v%0d_high", i), h, vecs[i].exp_half);
            measure_half(vecs[i].ch, 1'b0, 1, l, bad);
            check($sformatf("v%0d_low", i), l, vecs[i].exp_half);
            check($sformatf("v%0d_tick_rise2", i), int'(tick[vecs[i].ch]), 1);
            check($sformatf("v%0d_stray_ticks", i), bad, 0);
            stop_ch(vecs[i].ch);
        end

        // ---- divisor shrink mid high phase: applies at the next boundary
        bad = 0;
        load_div(0, 10);
        en[0] = 1'b1;
        wait_rise(0, n);
        check("shrink_latency", n, 11);
        repeat (5) cyc();
        load[0] = 1'b1;
        div_in[0 +: CNT_W] = CNT_W'(3);
        cyc();
        load[0] = 1'b0;
        measure_half(0, 1'b1, 7, h, bad);
        check("shrink_old_high", h, 10);
        measure_half(0, 1'b0, 1, l, bad);
        check("shrink_new_low", l, 3);
        measure_half(0, 1'b1, 1, h, bad);
        check("shrink_new_high", h, 3);
        stop_ch(0);

        // ---- en dropped inside a high phase: the high phase completes
        bad = 0;
        load_div(0, 6);
        en[0] = 1'b1;
        wait_rise(0, n);
        repeat (2) cyc();
        en[0] = 1'b0;
        measure_half(0, 1'b1, 3, h, bad);
        check("stop_high_len", h, 6);
        check("stop_busy_at_fall", int'(busy[0]), 0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (tick[0] || clk_out[0]) n++;
        end
        check("stop_no_activity", n, 0);

        // ---- two channels concurrently, div 1 and div 5
        load = 2'b11;
        div_in[0 +: CNT_W]     = CNT_W'(1);
        div_in[CNT_W +: CNT_W] = CNT_W'(5);
        cyc();
        load = '0;
        en   = 2'b11;
        prev = '0;
        per[0] = 2;
        per[1] = 10;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt[c] = 0; last[c] = 0; badint[c] = 0; mism[c] = 0;
        end
        for (int s = 1; s <= 60; s++) begin
            cyc();
            for (int c = 0; c < NUM_CH; c++) begin
                if (tick[c] != (clk_out[c] && !prev[c])) mism[c]++;
                if (tick[c]) begin
                    cnt[c]++;
                    if (last[c] > 0 && (s - last[c]) != per[c]) badint[c]++;
                    last[c] = s;
                end
            end
            prev = clk_out;
        end
        check("dual_ch0_ticks", cnt[0], 30);
        check("dual_ch1_ticks", cnt[1], 6);
        check("dual_ch0_period", badint[0], 0);
        check("dual_ch1_period", badint[1], 0);
        check("dual_ch0_tick_align", mism[0], 0);
        check("dual_ch1_tick_align", mism[1], 0);
        stop_ch(0);
        stop_ch(1);

`ifdef STEP_CLK_PCNT_EN
        // ---- pulse target: exactly 3 pulses, done sticky until en toggles
        pcnt_target[0 +: PCNT_W] = PCNT_W'(3);
        load_div(0, 2);
        en[0] = 1'b1;
        n = 0; h = 0; l = 0;
        for (int s = 0; s < 40; s++) begin
            cyc();
            if (tick[0]) n++;
            if (clk_out[0]) h++;
            else if (h > 0) begin
                l = h;
                h = 0;
            end
        end
        check("pcnt_ticks", n, 3);
        check("pcnt_last_high", l, 2);
        check("pcnt_done", int'(done[0]), 1);
        check("pcnt_busy", int'(busy[0]), 0);
        n = 0;
        for (int s = 0; s < 10; s++) begin
            cyc();
            if (busy[0] || !done[0]) n++;
        end
        check("pcnt_hold_idle", n, 0);
        en[0] = 1'b0;
        cyc();
        en[0] = 1'b1;
        wait_rise(0, n);
        check("pcnt_restart_lat", n, 3);
        check("pcnt_done_cleared", int'(done[0]), 0);
        pcnt_target = '0;
        stop_ch(0);
`else
        check("done_tied_low", int'(done), 0);
`endif

        // ---- async reset inside a high phase, then a full first phase
        bad = 0;
        load_div(1, 8);
        en[1] = 1'b1;
        wait_rise(1, n);
        repeat (3) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_clk_out", int'(clk_out), 0);
        check("arst_busy",    int'(busy),    0);
        check("arst_tick",    int'(tick),    0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load_div(1, 8);
        wait_rise(1, n);
        check("arst_restart_lat", n, 9);
        measure_half(1, 1'b1, 1, h, bad);
        check("arst_restart_high", h, 8);
        check("arst_stray_ticks", bad, 0);
        stop_ch(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
